pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage RISC-V core; drives stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers.
- Resolves load-use hazards, taken-branch/jump redirects and multi-cycle data-memory waits.
- Sequential parts: a memory-wait FSM, a wait-cycle timeout counter and stall/flush performance counters.

Parameters:
- TIMEOUT, 255, max MEM_WAIT cycles before MemTimeout sets; range 1..2^CNTW-1.
- CNTW, 8, width of the wait-cycle counter.
- PERFW, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D  in  5  rs1 of the instruction in Decode.
- Rs2D  in  5  rs2 of the instruction in Decode.
- RdE  in  5  rd of the instruction in Execute.
- LoadE  in  1  Execute holds a load (ResultSrc = memory).
- PCSrcE  in  1  taken branch/jump resolved in Execute.
- MemReqM  in  1  Memory stage issues a data-memory access.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- StallM  out  1  hold E/M register.
- FlushD  out  1  clear F/D register.
- FlushE  out  1  clear D/E register.
- FlushW  out  1  insert bubble into M/W register.
- MemTimeout  out  1  sticky: a memory wait exceeded TIMEOUT.
- StallCount  out  PERFW  cycles with StallF=1.
- FlushCount  out  PERFW  branch redirects taken.

Behaviour:
- Reset (async, rst=1): state=RUN, wait counter=0, MemTimeout=0, both perf counters=0. All stalls=0. FlushD=FlushE=1 while rst is high, so downstream registers clear.
- States: RUN, MEM_WAIT. All stall/flush outputs are combinational from state plus inputs (0-cycle latency).
- memwait = MemReqM & ~MemReadyM.
- loaduse = LoadE & (RdE!=0) & ((RdE==Rs1D) | (RdE==Rs2D)).
- RUN, priority memwait > PCSrcE > loaduse:
  - memwait: StallF=StallD=StallE=StallM=1, FlushW=1. Next state MEM_WAIT; counter<=1.
  - PCSrcE: FlushD=FlushE=1, no stalls; FlushCount+1.
  - loaduse: StallF=StallD=1, FlushE=1 (one bubble). Next cycle RdE is bubble rd=0, so the hazard clears without extra state.
  - PCSrcE & loaduse together: the redirect wins. The Decode instruction is wrong-path, so no stall.
  - Otherwise: all outputs 0.
- MEM_WAIT:
  - StallF/D/E/M=1 and FlushW=1 every cycle while MemReadyM=0. The counter increments, saturating at 2^CNTW-1.
  - When the counter reaches TIMEOUT: MemTimeout<=1 (sticky until rst). Stall continues; no abort.
  - MemReadyM=1: that cycle all stalls=0, FlushW=0, so the result advances. Next state RUN; counter<=0.
  - PCSrcE and loaduse are ignored in MEM_WAIT because Execute is frozen. They are re-evaluated on the release cycle with RUN priority, minus memwait. Redirect and release in the same cycle: FlushD=FlushE=1 and stalls=0.
  - MemReqM dropping while MemReadyM=0 is illegal (assertion); the FSM treats it as ready.
- Perf counters:
  - StallCount increments every cycle StallF=1.
  - FlushCount increments every cycle FlushD=1 caused by PCSrcE (not reset flushes).
  - Both wrap modulo 2^PERFW.
- Reset mid-MEM_WAIT: immediate return to RUN. Stalls drop asynchronously and flushes assert.

Decomposition:
- Shared package pipe_pkg: state enum (RUN, MEM_WAIT), REG_ZERO=5'd0, and a ctrl_t struct bundling the seven stall/flush bits for reuse by the pipeline-register wrappers.
- One natural sub-module, hazard_detect: purely combinational loaduse compare. The FSM, counters and output muxing stay in pipe_ctrl.

Test Plan:
- Reset: hold rst 3 cycles mid-operation -> FlushD=FlushE=1, stalls=0, counters=0, MemTimeout=0; after release all outputs 0.
- Load-use: LoadE=1, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 exactly one cycle. Same with RdE=0 -> no stall. StallCount=1.
- Branch: PCSrcE=1 with loaduse also true -> FlushD=FlushE=1, StallF=0; FlushCount=1.
- Memory wait: MemReqM=1, MemReadyM low 4 cycles then high -> StallF..StallM and FlushW high 4 cycles, low on the ready cycle, state back to RUN; StallCount=4.
- Timeout: TIMEOUT=3, MemReadyM low 6 cycles -> MemTimeout rises on the 3rd wait cycle and stays 1 after release; PCSrcE held high during the wait -> FlushD/FlushE asserted only on the release cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the 5-stage pipeline control path: sequencer states,
// register-index constants and the stall/flush bundle used by the register wrappers.
package pipe_pkg;

    localparam int unsigned REGW = 5;
    localparam logic [REGW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic stallf;
        logic stalld;
        logic stalle;
        logic stallm;
        logic flushd;
        logic flushe;
        logic flushw;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the Execute load destination and the Decode sources.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REGW-1:0] rs1,
    input  logic [REGW-1:0] rs2,
    input  logic [REGW-1:0] rd,
    input  logic            load,
    output logic            loaduse_c
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign loaduse_c = load & (rd != REG_ZERO) & ((rd == rs1) | (rd == rs2));

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: load-use stalls, branch redirects and data-memory
// wait stalls, with a wait-cycle timeout flag and stall/flush performance counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNTW    = 8,
    parameter int unsigned PERFW   = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdE,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             MemTimeout,
    output logic [PERFW-1:0] StallCount,
    output logic [PERFW-1:0] FlushCount
);

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] wait_cnt;
    logic [CNTW-1:0] wait_cnt_nxt;
    logic            loaduse;
    logic            memwait;
    logic            redirect;
    logic            timeout_hit;
    ctrl_t           ctrl;
    ctrl_t           run_ctrl;
    ctrl_t           wait_ctrl;
    logic [PERFW-1:0] stall_cnt;
    logic [PERFW-1:0] flush_cnt;
    logic            mem_timeout;

    hazard_detect u_hazard_detect (
        .rs1       (Rs1D),
        .rs2       (Rs2D),
        .rd        (RdE),
        .load      (LoadE),
        .loaduse_c (loaduse)
    );

    assign memwait = MemReqM & ~MemReadyM;

    // Redirect/load-use decision shared by RUN and the MEM_WAIT release cycle
    always_comb begin
        run_ctrl = '0;
        if (PCSrcE) begin
            run_ctrl.flushd = 1'b1;
            run_ctrl.flushe = 1'b1;
        end else if (loaduse) begin
            run_ctrl.stallf = 1'b1;
            run_ctrl.stalld = 1'b1;
            run_ctrl.flushe = 1'b1;
        end
    end

    always_comb begin
        wait_ctrl        = '0;
        wait_ctrl.stallf = 1'b1;
        wait_ctrl.stalld = 1'b1;
        wait_ctrl.stalle = 1'b1;
        wait_ctrl.stallm = 1'b1;
        wait_ctrl.flushw = 1'b1;
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        ctrl         = '0;
        redirect     = 1'b0;
        unique case (state)
            RUN: begin
                if (memwait) begin
                    ctrl         = wait_ctrl;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = CNTW'(1);
                end else begin
                    ctrl     = run_ctrl;
                    redirect = PCSrcE;
                end
            end
            MEM_WAIT: begin
                // A dropped request is treated like a completed access
                if (memwait) begin
                    ctrl         = wait_ctrl;
                    wait_cnt_nxt = (wait_cnt == {CNTW{1'b1}}) ? wait_cnt : wait_cnt + CNTW'(1);
                end else begin
                    ctrl         = run_ctrl;
                    redirect     = PCSrcE;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end
            end
        endcase
        // Reset clears downstream registers and drops every stall immediately
        if (rst) begin
            ctrl        = '0;
            ctrl.flushd = 1'b1;
            ctrl.flushe = 1'b1;
            redirect    = 1'b0;
        end
    end

    assign timeout_hit = (state_nxt == MEM_WAIT) && (wait_cnt_nxt >= CNTW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Sticky timeout flag; only reset clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_timeout <= 1'b0;
        end else if (timeout_hit) begin
            mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctrl.stallf) begin
                stall_cnt <= stall_cnt + PERFW'(1);
            end
            if (redirect) begin
                flush_cnt <= flush_cnt + PERFW'(1);
            end
        end
    end

    assign StallF     = ctrl.stallf;
    assign StallD     = ctrl.stalld;
    assign StallE     = ctrl.stalle;
    assign StallM     = ctrl.stallm;
    assign FlushD     = ctrl.flushd;
    assign FlushE     = ctrl.flushe;
    assign FlushW     = ctrl.flushw;
    assign MemTimeout = mem_timeout;
    assign StallCount = stall_cnt;
    assign FlushCount = flush_cnt;

    // The memory stage must hold its request until the access completes
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (state == MEM_WAIT) |-> (MemReqM | MemReadyM));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected stall/flush vectors are queued as each
// cycle is driven and compared against the DUT outputs mid-cycle.
module tb_pipe_ctrl;

    localparam int unsigned TIMEOUT = 3;
    localparam int unsigned CNTW    = 8;
    localparam int unsigned PERFW   = 32;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_MW   = 7'b1111001;
    localparam logic [6:0] C_RST  = 7'b0000110;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [4:0]       rs1d, rs2d, rde;
    logic             loade, pcsrce, memreqm, memreadym;
    logic             stallf, stalld, stalle, stallm;
    logic             flushd, flushe, flushw;
    logic             memtimeout;
    logic [PERFW-1:0] stallcount, flushcount;
    logic [6:0]       ctrl_obs;

    int               checks = 0;
    int               errors = 0;
    logic [6:0]       exp_q[$];
    logic [PERFW-1:0] exp_stall = '0;
    logic [PERFW-1:0] exp_flush = '0;
    logic             exp_to    = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNTW    (CNTW),
        .PERFW   (PERFW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rs1D       (rs1d),
        .Rs2D       (rs2d),
        .RdE        (rde),
        .LoadE      (loade),
        .PCSrcE     (pcsrce),
        .MemReqM    (memreqm),
        .MemReadyM  (memreadym),
        .StallF     (stallf),
        .StallD     (stalld),
        .StallE     (stalle),
        .StallM     (stallm),
        .FlushD     (flushd),
        .FlushE     (flushe),
        .FlushW     (flushw),
        .MemTimeout (memtimeout),
        .StallCount (stallcount),
        .FlushCount (flushcount)
    );

    assign ctrl_obs = {stallf, stalld, stalle, stallm, flushd, flushe, flushw};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ld, input logic pc, input logic req, input logic rdy);
        rs1d      = rs1;
        rs2d      = rs2;
        rde       = rd;
        loade     = ld;
        pcsrce    = pc;
        memreqm   = req;
        memreadym = rdy;
    endtask

    // One pipeline cycle: drive after the edge, queue the expectation, compare mid-cycle
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ld, input logic pc,
                        input logic req, input logic rdy, input logic [6:0] exp);
        logic [6:0] want;
        @(posedge clk);
        #1;
        drive(rs1, rs2, rd, ld, pc, req, rdy);
        exp_q.push_back(exp);
        if (exp[6]) exp_stall = exp_stall + PERFW'(1);
        if (exp == C_BR) exp_flush = exp_flush + PERFW'(1);
        @(negedge clk);
        want = exp_q.pop_front();
        check(tag, 32'(ctrl_obs), 32'(want));
    endtask

    task automatic check_perf(input string tag);
        check({tag, "_stallcount"}, stallcount, exp_stall);
        check({tag, "_flushcount"}, flushcount, exp_flush);
        check({tag, "_timeout"}, 32'(memtimeout), 32'(exp_to));
    endtask

    initial begin
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_ctrl", 32'(ctrl_obs), 32'(C_RST));
            check_perf("rst");
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);

        // Load-use: one bubble, then the bubble's rd=0 clears it; rd=0 never hazards
        step("lu_hit",   5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
        step("lu_clear", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        step("lu_x0",    5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NONE);
        step("lu_rs2",   5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LU);
        step("idle",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        check_perf("lu");

        // Redirect wins over a simultaneous load-use
        step("br_lu", 5'd0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_BR);
        step("idle",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        check_perf("br");

        // Short memory wait below the timeout threshold
        for (int k = 0; k < 2; k++)
            step("mw_wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MW);
        step("mw_ready", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NONE);
        step("idle",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        check_perf("mw");

        // Long wait with redirect and load-use pending: both deferred to release
        for (int k = 1; k <= 6; k++) begin
            step("to_wait", 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_MW);
            if (k != 3) check("to_flag", 32'(memtimeout), 32'(k >= 4));
        end
        step("to_release", 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, C_BR);
        exp_to = 1'b1;
        step("idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        check_perf("to");

        // Load-use re-evaluated on the release cycle
        step("rl_wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MW);
        step("rl_lu",   5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, C_LU);
        step("rl_bub",  5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        check_perf("rl");

        // Reset in the middle of a memory wait
        step("mr_wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MW);
        step("mr_wait", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MW);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        exp_stall = '0;
        exp_flush = '0;
        exp_to    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mr_rst_ctrl", 32'(ctrl_obs), 32'(C_RST));
            check_perf("mr_rst");
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("mr_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        step("mr_br",   5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR);
        step("idle",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE);
        check_perf("mr");

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
